stepper_step_driver: RTL

Consumer end of the simulator's `delta_steps` output. Once per simulation period it accepts a signed step count. It then emits that many STEP/DIR pulses to the stepper driver chip, spread evenly over one simulation period by a DDA accumulator. It also keeps a count of pulses actually issued, so the physical motor position can be compared with the simulator's `current_pos` (1/16 microstep, 0.1125°/step).

---
 rtl/stepper_pkg.sv | 27 ++
 rtl/stepper_step_driver_dda.sv | 64 ++++++
 rtl/stepper_step_driver.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
//
// Shared definitions for the stepper STEP/DIR driver:
//   - state_t          : command FSM states (IDLE, RUN)
//   - STEP_W           : width of the signed step command and position counter
//   - STEP_ANGLE_MDEG  : mechanical angle of one 1/16 microstep, millidegrees
//   - max_steps()      : largest step count one simulation period can carry
//                        without violating the minimum STEP period
// -----------------------------------------------------------------------------
package stepper_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int STEP_W = 16;

    // 1.8 deg full step / 16 microsteps = 0.1125 deg = 112.5 mdeg
    localparam real STEP_ANGLE_MDEG = 112.5;

    function automatic int max_steps(input int sim_period, input int min_step_period);
        return sim_period / min_step_period;
    endfunction

endpackage

// File: rtl/stepper_step_driver_dda.sv
// -----------------------------------------------------------------------------
// stepper_dda
//
// Digital differential analyser that spreads `mag` fire events evenly across
// one simulation period of SIM_PERIOD clocks. Each active cycle adds `mag` to
// the accumulator; whenever the sum reaches SIM_PERIOD, SIM_PERIOD is removed
// and `fire` is asserted for that cycle. With acc starting at zero, the n-th
// fire lands on active cycle ceil(n*SIM_PERIOD/mag) and the last one on cycle
// SIM_PERIOD exactly.
//
// Ports:
//   clock  in  : system clock
//   reset  in  : asynchronous active-low reset
//   mag    in  : steps to spread over the period (<= SIM_PERIOD)
//   start  in  : restart the period (acc and period_cnt cleared)
//   run    in  : evaluate the accumulator this cycle; low clears it
//   fire   out : combinational; a step is due at the end of this cycle
// -----------------------------------------------------------------------------
module stepper_dda #(
    parameter int SIM_PERIOD = 500_000,
    parameter int MAG_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [MAG_W-1:0] mag,
    input  logic             start,
    input  logic             run,
    output logic             fire
);

    localparam int ACC_W = $clog2(SIM_PERIOD) + 1;
    localparam int CNT_W = $clog2(SIM_PERIOD + 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] period_cnt;
    logic [31:0]      sum;
    logic             in_window;

    always_comb begin
        sum       = 32'(acc) + 32'(mag);
        // Guard so the accumulator never runs past the end of its period.
        in_window = 32'(period_cnt) < 32'(SIM_PERIOD);
        fire      = run && in_window && (sum >= 32'(SIM_PERIOD));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            period_cnt <= '0;
        end else if (start) begin
            acc        <= '0;
            period_cnt <= '0;
        end else if (run) begin
            if (in_window) begin
                acc        <= fire ? ACC_W'(sum - 32'(SIM_PERIOD)) : ACC_W'(sum);
                period_cnt <= period_cnt + CNT_W'(1);
            end
        end else begin
            acc        <= '0;
            period_cnt <= '0;
        end
    end

endmodule

// File: rtl/stepper_step_driver.sv
// -----------------------------------------------------------------------------
// stepper_step_driver
//
// Consumer of the simulator's per-period `delta_steps`. Each accepted command
// is converted into |delta_steps| STEP pulses (clamped to MAX_STEPS) spread
// evenly over one simulation period, with DIR set from the command sign. A
// signed count of issued pulses is kept in `motor_pos` for comparison with the
// simulator's position.
//
// Ports:
//   clock        in  : system clock (50 MHz)
//   reset        in  : asynchronous active-low reset
//   delta_valid  in  : single-cycle strobe qualifying delta_steps
//   delta_steps  in  : signed step count for this period
//   enable       in  : motion enable; low aborts motion and ignores commands
//   step         out : STEP pulse, PULSE_WIDTH clocks high
//   dir          out : 1 = positive direction
//   busy         out : a command is executing (RUN state)
//   motor_pos    out : net issued pulses, two's-complement wrap
//   clamped      out : sticky, a command exceeded MAX_STEPS
//   overrun      out : sticky, a running command was replaced by a newer one
// -----------------------------------------------------------------------------
module stepper_step_driver
    import stepper_pkg::*;
#(
    parameter int SIM_PERIOD      = 500_000,
    parameter int MIN_STEP_PERIOD = 500,
    parameter int PULSE_WIDTH     = 100,
    parameter int DIR_SETUP       = 50
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     delta_valid,
    input  logic signed [STEP_W-1:0] delta_steps,
    input  logic                     enable,
    output logic                     step,
    output logic                     dir,
    output logic                     busy,
    output logic signed [STEP_W-1:0] motor_pos,
    output logic                     clamped,
    output logic                     overrun
);

    localparam int MAX_STEPS = max_steps(SIM_PERIOD, MIN_STEP_PERIOD);
    localparam int PW_W      = $clog2(PULSE_WIDTH + 1);

    // The first pulse of a command comes at least MIN_STEP_PERIOD after the
    // accept; a deferred DIR change happens at most PULSE_WIDTH after it, so
    // this relation is what guarantees DIR setup time at the driver chip.
    if (PULSE_WIDTH + DIR_SETUP > MIN_STEP_PERIOD) begin : g_param_check
        $error("stepper_step_driver: PULSE_WIDTH + DIR_SETUP exceeds MIN_STEP_PERIOD");
    end

    state_t state, state_next;

    logic                     accept;
    logic signed [STEP_W:0]   steps_wide;
    logic        [STEP_W:0]   abs_steps;
    logic                     over_max;
    logic        [STEP_W-1:0] new_mag;
    logic                     new_dir;

    logic        [STEP_W-1:0] mag;
    logic        [STEP_W-1:0] remaining;
    logic                     dda_run;
    logic                     dda_fire;
    logic                     fire;

    logic        [PW_W-1:0]   pw_cnt;
    logic                     pulse_hold;
    logic                     dir_pend;
    logic                     dir_pend_val;

    // Command decode
    always_comb begin
        accept     = delta_valid && enable;
        // Magnitude at 17 bits so that -32768 has a representable absolute value.
        steps_wide = 17'(delta_steps);
        abs_steps  = steps_wide[STEP_W] ? $unsigned(-steps_wide) : $unsigned(steps_wide);
        over_max   = abs_steps > 17'(MAX_STEPS);
        new_mag    = over_max ? STEP_W'(MAX_STEPS) : abs_steps[STEP_W-1:0];
        new_dir    = ~delta_steps[STEP_W-1];
    end

    assign dda_run = (state == RUN) && enable;
    assign busy    = (state == RUN);

    stepper_dda #(
        .SIM_PERIOD (SIM_PERIOD),
        .MAG_W      (STEP_W)
    ) u_dda (
        .clock (clock),
        .reset (reset),
        .mag   (mag),
        .start (accept),
        .run   (dda_run),
        .fire  (dda_fire)
    );

    always_comb begin
        fire       = dda_fire && (remaining != '0);
        // STEP is (or is about to be) high after this edge: DIR must not move.
        pulse_hold = fire || (step && (pw_cnt != '0));
    end

    // Command FSM
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = (new_mag != '0) ? RUN : IDLE;
        end else if (state == RUN) begin
            // The final fire always lands on the last cycle of the period.
            if (!enable || (fire && (remaining == STEP_W'(1)))) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command bookkeeping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mag       <= '0;
            remaining <= '0;
            clamped   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                mag       <= new_mag;
                remaining <= new_mag;
            end else if (!enable) begin
                remaining <= '0;
            end else if (fire) begin
                remaining <= remaining - STEP_W'(1);
            end
            clamped <= clamped | (accept && over_max);
            overrun <= overrun | (accept && (state == RUN));
        end
    end

    // STEP pulse generator: a started pulse always runs its full width
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step   <= 1'b0;
            pw_cnt <= '0;
        end else if (fire) begin
            step   <= 1'b1;
            pw_cnt <= PW_W'(PULSE_WIDTH - 1);
        end else if (step) begin
            if (pw_cnt == '0) begin
                step <= 1'b0;
            end else begin
                pw_cnt <= pw_cnt - PW_W'(1);
            end
        end
    end

    // DIR: immediate when STEP is idle, otherwise applied on the falling edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dir          <= 1'b1;
            dir_pend     <= 1'b0;
            dir_pend_val <= 1'b1;
        end else if (accept) begin
            if (pulse_hold) begin
                dir_pend     <= 1'b1;
                dir_pend_val <= new_dir;
            end else begin
                dir      <= new_dir;
                dir_pend <= 1'b0;
            end
        end else if (dir_pend && !pulse_hold) begin
            dir      <= dir_pend_val;
            dir_pend <= 1'b0;
        end
    end

    // Position tracks the pulse being issued, using the DIR it is issued with
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            motor_pos <= '0;
        end else if (fire) begin
            motor_pos <= dir ? motor_pos + 16'sd1 : motor_pos - 16'sd1;
        end
    end

endmodule
